// File: rtl/seg7_reader.sv
// seg7_reader: samples a 7-segment bus, filters glitches and decodes stable glyphs to hex.
// Each accepted change is classified as an up step, a down step or a jump, with running counts.
module seg7_reader #(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] digit,
  output logic       digit_vld,
  output logic       blank,
  output logic       invalid,
  output logic       upd,
  output logic       step_up,
  output logic       step_down,
  output logic       step_jump,
  output logic [7:0] up_cnt,
  output logic [7:0] down_cnt
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_TRACK  = 2'd2;
  localparam logic [7:0] CNT_MAX   = 8'(STABLE_CYCLES - 1);

  logic [6:0] s_q, s_d, c_q, c_d;
  logic [7:0] cnt_q, cnt_d, up_cnt_q, up_cnt_d, down_cnt_q, down_cnt_d;
  logic       c_none_q, c_none_d;
  logic [1:0] state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       digit_vld_q, digit_vld_d, blank_q, blank_d, invalid_q, invalid_d;
  logic       upd_q, upd_d, step_up_q, step_up_d, step_down_q, step_down_d;
  logic       step_jump_q, step_jump_d;
  logic       accept;
  logic [4:0] dec;

  // Returns {legal, value}; legal=0 for blank and for unknown patterns.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    s_d = ACTIVE_LOW ? ~seg_in : seg_in;
    if (s_d != s_q)          cnt_d = 8'd0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 8'd1;

    // Decided on the incoming sample so upd appears the cycle after the final stable edge.
    accept = (cnt_d == CNT_MAX) && (c_none_q || (s_d != c_q));
    dec    = decode(s_d);

    c_d         = c_q;
    c_none_d    = c_none_q;
    digit_d     = digit_q;
    digit_vld_d = digit_vld_q;
    blank_d     = blank_q;
    invalid_d   = invalid_q;
    upd_d       = 1'b0;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    step_jump_d = 1'b0;
    up_cnt_d    = up_cnt_q;
    down_cnt_d  = down_cnt_q;

    if (accept) begin
      c_d      = s_d;
      c_none_d = 1'b0;
      upd_d    = 1'b1;
      if (dec[4]) begin
        digit_d     = dec[3:0];
        digit_vld_d = 1'b1;
        blank_d     = 1'b0;
        invalid_d   = 1'b0;
        if (!digit_vld_q)                   step_jump_d = 1'b1;
        else if (dec[3:0] == digit_q + 4'd1) step_up_d   = 1'b1;
        else if (dec[3:0] == digit_q - 4'd1) step_down_d = 1'b1;
        else                                 step_jump_d = 1'b1;
      end else begin
        blank_d     = (s_d == 7'h00);
        invalid_d   = (s_d != 7'h00);
        step_jump_d = 1'b1;
      end
      if (step_up_d)   up_cnt_d   = up_cnt_q + 8'd1;
      if (step_down_d) down_cnt_d = down_cnt_q + 8'd1;
    end

    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = accept ? ST_TRACK : ST_SETTLE;
      ST_SETTLE: if (accept || (!c_none_q && (s_d == c_q))) state_d = ST_TRACK;
      ST_TRACK:  if (!accept && (s_d != c_q)) state_d = ST_SETTLE;
      default:   state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= 7'h00;
      cnt_q       <= 8'd0;
      c_q         <= 7'h00;
      c_none_q    <= 1'b1;
      state_q     <= ST_INIT;
      digit_q     <= 4'd0;
      digit_vld_q <= 1'b0;
      blank_q     <= 1'b0;
      invalid_q   <= 1'b0;
      upd_q       <= 1'b0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      step_jump_q <= 1'b0;
      up_cnt_q    <= 8'd0;
      down_cnt_q  <= 8'd0;
    end else begin
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      c_none_q    <= c_none_d;
      state_q     <= state_d;
      digit_q     <= digit_d;
      digit_vld_q <= digit_vld_d;
      blank_q     <= blank_d;
      invalid_q   <= invalid_d;
      upd_q       <= upd_d;
      step_up_q   <= step_up_d;
      step_down_q <= step_down_d;
      step_jump_q <= step_jump_d;
      up_cnt_q    <= up_cnt_d;
      down_cnt_q  <= down_cnt_d;
    end
  end

  assign digit     = digit_q;
  assign digit_vld = digit_vld_q;
  assign blank     = blank_q;
  assign invalid   = invalid_q;
  assign upd       = upd_q;
  assign step_up   = step_up_q;
  assign step_down = step_down_q;
  assign step_jump = step_jump_q;
  assign up_cnt    = up_cnt_q;
  assign down_cnt  = down_cnt_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed and random patterns checked every cycle against
// a model that accepts a pattern once it has been seen in N consecutive samples.
module tb_seg7_reader;

  localparam bit ACTIVE_LOW = 1'b1;
  localparam int N          = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] digit;
  logic       digit_vld, blank, invalid, upd, step_up, step_down, step_jump;
  logic [7:0] up_cnt, down_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] glyph [0:15];
  logic [6:0] hist [$];
  logic [6:0] com;
  logic       com_none;
  logic [3:0] e_digit;
  logic       e_vld, e_blank, e_invalid, e_upd, e_up, e_down, e_jump;
  logic [7:0] e_upc, e_downc;

  seg7_reader #(.ACTIVE_LOW(ACTIVE_LOW), .STABLE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit(digit), .digit_vld(digit_vld),
    .blank(blank), .invalid(invalid), .upd(upd), .step_up(step_up),
    .step_down(step_down), .step_jump(step_jump), .up_cnt(up_cnt), .down_cnt(down_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag);
    logic [26:0] obs, exp;
    obs = {digit, digit_vld, blank, invalid, upd, step_up, step_down, step_jump, up_cnt, down_cnt};
    exp = {e_digit, e_vld, e_blank, e_invalid, e_upd, e_up, e_down, e_jump, e_upc, e_downc};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h (digit,vld,blank,inv,upd,up,dn,jmp,upc,dnc)",
             tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    hist.push_back(7'h00);
    com = 7'h00; com_none = 1'b1;
    e_digit = 4'd0; e_vld = 1'b0; e_blank = 1'b0; e_invalid = 1'b0;
    e_upd = 1'b0; e_up = 1'b0; e_down = 1'b0; e_jump = 1'b0;
    e_upc = 8'd0; e_downc = 8'd0;
  endtask

  // One clock edge of the model: accept when the last N samples agree and differ from the committed one.
  task automatic modelSample(input logic [6:0] lit);
    bit stable;
    int idx, diff;
    hist.push_back(lit);
    if (hist.size() > N) void'(hist.pop_front());
    stable = (hist.size() == N);
    foreach (hist[i]) if (hist[i] != lit) stable = 0;
    e_upd = 1'b0; e_up = 1'b0; e_down = 1'b0; e_jump = 1'b0;
    if (stable && (com_none || lit != com)) begin
      com = lit; com_none = 1'b0; e_upd = 1'b1;
      idx = -1;
      for (int v = 0; v < 16; v++) if (glyph[v] == lit) idx = v;
      if (idx < 0) begin
        e_blank = (lit == 7'h00); e_invalid = (lit != 7'h00); e_jump = 1'b1;
      end else begin
        diff = (idx - int'(e_digit) + 16) % 16;
        if (!e_vld)          e_jump = 1'b1;
        else if (diff == 1)  e_up = 1'b1;
        else if (diff == 15) e_down = 1'b1;
        else                 e_jump = 1'b1;
        e_digit = 4'(idx); e_vld = 1'b1; e_blank = 1'b0; e_invalid = 1'b0;
        if (e_up)   e_upc   = 8'((int'(e_upc) + 1) % 256);
        if (e_down) e_downc = 8'((int'(e_downc) + 1) % 256);
      end
    end
  endtask

  task automatic applyStimulus(input logic [6:0] lit, input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      seg_in = ACTIVE_LOW ? ~lit : lit;
      @(posedge clk); #1;
      modelSample(lit);
      checkOutput(tag);
    end
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    checkOutput(tag);
  endtask

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst = 1'b1;
    seg_in = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    doReset("reset");

    applyStimulus(7'h3F, 8, "first_zero");
    applyStimulus(7'h06, 6, "up_0_1");
    applyStimulus(7'h5B, 6, "up_1_2");
    applyStimulus(7'h06, 6, "down_2_1");
    applyStimulus(7'h71, 6, "jump_to_F");
    applyStimulus(7'h3F, 6, "wrap_F_0");
    applyStimulus(7'h71, 6, "wrap_0_F");
    applyStimulus(7'h4F, 6, "show_3");
    applyStimulus(7'h7F, 2, "glitch_8");
    applyStimulus(7'h4F, 6, "after_glitch");
    applyStimulus(7'h66, 6, "show_4");
    applyStimulus(7'h00, 6, "blank");
    applyStimulus(7'h6D, 6, "up_after_blank");
    applyStimulus(7'h01, 6, "invalid");

    doReset("reset_before_wrap");
    applyStimulus(glyph[0], 5, "wrap_start");
    for (int i = 1; i <= 256; i++) applyStimulus(glyph[i % 16], 4, "up_256");
    assert (up_cnt === 8'd0) else begin
      miscompares++;
      $error("[TB] FAIL up_cnt_wrap observed=%0d expected=0", up_cnt);
    end
    vectors++;

    applyStimulus(glyph[3], 3, "settle_then_reset");
    doReset("reset_over_accept");
    applyStimulus(glyph[3], 6, "first_after_reset");

    for (int n = 0; n < 60; n++) begin
      logic [6:0] p;
      if ($urandom_range(0, 3) != 0) p = glyph[$urandom_range(0, 15)];
      else                           p = 7'($urandom);
      applyStimulus(p, int'($urandom_range(1, 6)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
